// File: rtl/acc_prd_sequencer.sv
// Offload predecode sequencer: one core port fanned out to NumAcc predecoders,
// lowest-index winner selection and per-accelerator in-flight credit limiting.
module acc_prd_sequencer #(
  parameter int NumAcc         = 4,
  parameter int MaxOutstanding = 4,
  parameter int NumRs          = 3,
  parameter int WbWidth        = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      q_valid_i,
  output logic                      q_ready_o,
  input  logic [31:0]               q_instr_data_i,
  output logic                      p_valid_o,
  input  logic                      p_ready_i,
  output logic                      p_accept_o,
  output logic [WbWidth-1:0]        p_writeback_o,
  output logic [NumRs-1:0]          p_use_rs_o,
  output logic [NumAcc-1:0]         p_acc_sel_o,
  output logic                      p_conflict_o,
  output logic [31:0]               prd_instr_o,
  input  logic [NumAcc-1:0]         prd_accept_i,
  input  logic [NumAcc*WbWidth-1:0] prd_writeback_i,
  input  logic [NumAcc*NumRs-1:0]   prd_use_rs_i,
  input  logic [NumAcc-1:0]         acc_retire_i
);

  localparam int CW = $clog2(MaxOutstanding + 1);
  localparam int IW = (NumAcc > 1) ? $clog2(NumAcc) : 1;
  localparam logic [CW-1:0] MaxCnt = CW'(MaxOutstanding);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    STALL,
    RESP
  } state_t;

  state_t              state;
  logic [31:0]         instr_q;
  logic [IW-1:0]       win_q;
  logic                accept_q;
  logic                conflict_q;
  logic [NumAcc-1:0]   sel_q;
  logic [WbWidth-1:0]  wb_q;
  logic [NumRs-1:0]    rs_q;
  logic [CW-1:0]       cnt [NumAcc];

  logic                hit;
  logic                multi;
  logic [IW-1:0]       win;
  logic [NumAcc-1:0]   win_oh;
  logic                eval_room;
  logic                stall_go;
  logic [NumAcc-1:0]   inc;

  // Lowest accepting index wins; any second accept flags a conflict.
  always_comb begin
    hit   = 1'b0;
    multi = 1'b0;
    win   = '0;
    for (int i = 0; i < NumAcc; i++) begin
      if (prd_accept_i[i]) begin
        if (hit) multi = 1'b1;
        else     win   = IW'(i);
        hit = 1'b1;
      end
    end
  end

  assign win_oh    = NumAcc'(1) << win;
  assign eval_room = cnt[win] < MaxCnt;
  assign stall_go  = (cnt[win_q] < MaxCnt) || acc_retire_i[win_q];

  always_comb begin
    inc = '0;
    if (state == EVAL && hit && eval_room) inc[win] = 1'b1;
    if (state == STALL && stall_go) inc[win_q] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      instr_q    <= '0;
      win_q      <= '0;
      accept_q   <= 1'b0;
      conflict_q <= 1'b0;
      sel_q      <= '0;
      wb_q       <= '0;
      rs_q       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (q_valid_i) begin
            instr_q <= q_instr_data_i;
            state   <= EVAL;
          end
        end
        EVAL: begin
          win_q      <= win;
          accept_q   <= hit;
          conflict_q <= multi;
          sel_q      <= hit ? win_oh : '0;
          wb_q       <= hit ? prd_writeback_i[int'(win)*WbWidth +: WbWidth] : '0;
          rs_q       <= hit ? prd_use_rs_i[int'(win)*NumRs +: NumRs] : '0;
          state      <= (hit && !eval_room) ? STALL : RESP;
        end
        STALL: begin
          if (stall_go) state <= RESP;
        end
        RESP: begin
          if (p_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Retire on an empty counter is dropped; inc with retire cancels out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumAcc; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NumAcc; i++) begin
        if (inc[i] && !acc_retire_i[i])
          cnt[i] <= cnt[i] + CW'(1);
        else if (!inc[i] && acc_retire_i[i] && cnt[i] != '0)
          cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

  assign q_ready_o     = (state == IDLE) && !rst_i;
  assign p_valid_o     = (state == RESP) && !rst_i;
  assign p_accept_o    = accept_q;
  assign p_writeback_o = wb_q;
  assign p_use_rs_o    = rs_q;
  assign p_acc_sel_o   = sel_q;
  assign p_conflict_o  = conflict_q;
  assign prd_instr_o   = instr_q;

endmodule

// File: tb/tb_acc_prd_sequencer.sv
// Bench for acc_prd_sequencer: directed scenarios plus randomized traffic
// checked against a credit-count reference model.
module tb_acc_prd_sequencer;

  localparam int NA = 4;
  localparam int MO = 4;
  localparam int NR = 3;
  localparam int WB = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             q_valid;
  logic             q_ready;
  logic [31:0]      q_instr;
  logic             p_valid;
  logic             p_ready;
  logic             p_accept;
  logic [WB-1:0]    p_wb;
  logic [NR-1:0]    p_rs;
  logic [NA-1:0]    p_sel;
  logic             p_conflict;
  logic [31:0]      prd_instr;
  logic [NA-1:0]    prd_accept;
  logic [NA*WB-1:0] prd_wb;
  logic [NA*NR-1:0] prd_rs;
  logic [NA-1:0]    retire;

  int n_cmp = 0;
  int n_err = 0;
  int mcnt[NA];

  acc_prd_sequencer #(
    .NumAcc(NA), .MaxOutstanding(MO), .NumRs(NR), .WbWidth(WB)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .q_valid_i(q_valid),
    .q_ready_o(q_ready),
    .q_instr_data_i(q_instr),
    .p_valid_o(p_valid),
    .p_ready_i(p_ready),
    .p_accept_o(p_accept),
    .p_writeback_o(p_wb),
    .p_use_rs_o(p_rs),
    .p_acc_sel_o(p_sel),
    .p_conflict_o(p_conflict),
    .prd_instr_o(prd_instr),
    .prd_accept_i(prd_accept),
    .prd_writeback_i(prd_wb),
    .prd_use_rs_i(prd_rs),
    .acc_retire_i(retire)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full offload: offer, evaluate, optional stall, held response.
  task automatic txn(input logic [31:0] instr, input logic [NA-1:0] acc,
                     input logic [NA*WB-1:0] wbv, input logic [NA*NR-1:0] rsv,
                     input int hold, input bit rnd_ret, input string tag);
    int w;
    int r;
    bit full;
    logic [9:0] exp_vec;
    logic [11:0] obs;
    w = -1;
    for (int i = NA - 1; i >= 0; i--) if (acc[i]) w = i;
    if (w >= 0)
      exp_vec = {1'b1, NA'(1 << w), wbv[w*WB +: WB], rsv[w*NR +: NR],
                 1'($countones(acc) > 1)};
    else
      exp_vec = '0;
    full = (w >= 0) && (mcnt[w] == MO);
    n_cmp++;
    if (q_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s idle_ready got %b want 1", tag, q_ready);
    end
    q_valid = 1'b1; q_instr = instr;
    prd_accept = acc; prd_wb = wbv; prd_rs = rsv;
    step();
    q_valid = 1'b0; q_instr = $urandom;
    n_cmp++;
    if ({q_ready, p_valid, prd_instr} !== {2'b00, instr}) begin
      n_err++;
      $display("FAIL %s eval got rdy=%b vld=%b instr=%h want 0 0 %h",
               tag, q_ready, p_valid, prd_instr, instr);
    end
    step();
    prd_accept = 4'($urandom); prd_wb = 4'($urandom); prd_rs = 12'($urandom);
    if (full) begin
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (p_valid !== 1'b0) begin
          n_err++;
          $display("FAIL %s stall_valid got %b want 0", tag, p_valid);
        end
        step();
      end
      retire[w] = 1'b1;
      step();
      retire = '0;
    end else if (w >= 0) begin
      mcnt[w]++;
    end
    for (int k = 0; k <= hold; k++) begin
      obs = {p_valid, q_ready, p_accept, p_sel, p_wb, p_rs, p_conflict};
      n_cmp++;
      if (obs !== {2'b10, exp_vec}) begin
        n_err++;
        $display("FAIL %s resp[%0d] got %b want %b", tag, k, obs, {2'b10, exp_vec});
      end
      if (k < hold) begin
        if (rnd_ret && $urandom_range(0, 1) == 1) begin
          r = $urandom_range(0, NA - 1);
          retire[r] = 1'b1;
          if (mcnt[r] > 0) mcnt[r]--;
        end
        step();
        retire = '0;
      end
    end
    p_ready = 1'b1;
    step();
    p_ready = 1'b0;
    n_cmp++;
    if ({q_ready, p_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL %s back_idle got rdy=%b vld=%b want 1 0", tag, q_ready, p_valid);
    end
    for (int i = 0; i < NA; i++) begin
      n_cmp++;
      if (dut.cnt[i] !== 3'(mcnt[i])) begin
        n_err++;
        $display("FAIL %s cnt[%0d] got %0d want %0d", tag, i, dut.cnt[i], mcnt[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; q_valid = 1'b0; q_instr = '0; p_ready = 1'b0;
    prd_accept = '0; prd_wb = '0; prd_rs = '0; retire = '0;
    for (int i = 0; i < NA; i++) mcnt[i] = 0;
    step();
    step();
    n_cmp++;
    if ({q_ready, p_valid, p_accept, p_sel, prd_instr} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got rdy=%b vld=%b acc=%b sel=%b instr=%h want all 0",
               q_ready, p_valid, p_accept, p_sel, prd_instr);
    end
    for (int i = 0; i < NA; i++) begin
      n_cmp++;
      if (dut.cnt[i] !== 3'd0) begin
        n_err++;
        $display("FAIL reset_cnt[%0d] got %0d want 0", i, dut.cnt[i]);
      end
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (q_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release q_ready got %b want 1", q_ready);
    end
  endtask

  task automatic test_basic();
    txn(32'h0000_000B, 4'b0010, 4'b0010, 12'h018, 0, 1'b0, "basic");
  endtask

  task automatic test_no_accept();
    txn(32'h1234_5678, 4'b0000, 4'b1111, 12'hFFF, 1, 1'b0, "no_accept");
  endtask

  task automatic test_conflict();
    txn(32'hCAFE_0001, 4'b0101, 4'b0100, 12'h1C5, 0, 1'b0, "conflict");
  endtask

  task automatic test_stall();
    for (int k = 0; k < MO + 1; k++)
      txn(32'hA000_0000 + k, 4'b1000, 4'b1000, 12'hA00, 0, 1'b0, "stall");
  endtask

  task automatic test_core_stall();
    txn(32'h0BAD_F00D, 4'b0100, 4'b0000, 12'h140, 10, 1'b0, "core_stall");
  endtask

  task automatic test_reset_in_stall();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NA; i++) mcnt[i] = 0;
    step();
    for (int k = 0; k < 4; k++) txn(32'h10 + k, 4'b0001, 4'b0001, 12'h007, 0, 1'b0, "fill0");
    for (int k = 0; k < 2; k++) txn(32'h20 + k, 4'b0010, 4'b0010, 12'h038, 0, 1'b0, "fill1");
    txn(32'h30, 4'b1000, 4'b1000, 12'hE00, 0, 1'b0, "fill3");
    q_valid = 1'b1; q_instr = 32'h40; prd_accept = 4'b0001;
    step();
    q_valid = 1'b0;
    step();
    n_cmp++;
    if (p_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_stall enter got p_valid=%b want 0", p_valid);
    end
    rst = 1'b1;
    step();
    for (int i = 0; i < NA; i++) mcnt[i] = 0;
    n_cmp++;
    if ({q_ready, p_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_stall outputs got rdy=%b vld=%b want 0 0", q_ready, p_valid);
    end
    rst = 1'b0;
    retire = '1;
    step();
    retire = '0;
    for (int i = 0; i < NA; i++) begin
      n_cmp++;
      if (dut.cnt[i] !== 3'd0) begin
        n_err++;
        $display("FAIL rst_stall cnt[%0d] got %0d want 0", i, dut.cnt[i]);
      end
    end
    n_cmp++;
    if ({q_ready, p_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL rst_stall idle got rdy=%b vld=%b want 1 0", q_ready, p_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 150; n++)
      txn($urandom, 4'($urandom), 4'($urandom), 12'($urandom),
          $urandom_range(0, 3), 1'b1, "random");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_accept();
    test_conflict();
    test_stall();
    test_core_stall();
    test_reset_in_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
